// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receiver, 8 data bits + parity, 1 or 2 stops.
// Delivers each byte with parity/framing/overrun flags on a valid/ready port.
module uart_rx_frame (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        parity_sel,
  input  logic        stop_sel,
  input  logic [11:0] baud_divisor,
  input  logic        ready_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        rx_s1;
  logic        rx_s2;
  logic        armed;
  logic [11:0] cnt;
  logic [11:0] div_q;
  logic [11:0] lim;
  logic        par_q;
  logic        stop_q;
  logic        pbit_q;
  logic        stop1_bad;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        tick;
  logic        start_det;
  logic        done;
  logic        consume;
  logic        ferr_new;
  logic        perr_new;

  assign start_det = (state_q == IDLE) && armed && !rx_s2;
  // START waits half a bit so every later sample lands mid-bit
  assign lim = (state_q == START) ? {1'b0, div_q[11:1]} : div_q;
  assign tick = (cnt == lim - 12'd1);
  assign consume = valid_out && ready_in;
  assign busy = (state_q != IDLE);

  assign ferr_new = !rx_s2 || ((state_q == STOP2) && stop1_bad);
  assign perr_new = ((^shreg) ^ pbit_q) != par_q;

  always_comb begin
    state_d = state_q;
    done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_det) state_d = START;
      end
      START: begin
        if (tick) state_d = rx_s2 ? IDLE : DATA;
      end
      DATA: begin
        if (tick && idx == 3'd7) state_d = PARITY;
      end
      PARITY: begin
        if (tick) state_d = STOP1;
      end
      STOP1: begin
        if (tick) begin
          state_d = stop_q ? STOP2 : IDLE;
          done = !stop_q;
        end
      end
      STOP2: begin
        if (tick) begin
          state_d = IDLE;
          done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      state_q     <= IDLE;
      armed       <= 1'b0;
      cnt         <= 12'd0;
      idx         <= 3'd0;
      shreg       <= 8'd0;
      div_q       <= 12'd4;
      par_q       <= 1'b0;
      stop_q      <= 1'b0;
      pbit_q      <= 1'b0;
      stop1_bad   <= 1'b0;
      data_out    <= 8'd0;
      valid_out   <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      state_q <= state_d;
      // a held-low line after a frame must go high before re-arming
      if (done) armed <= 1'b0;
      else if (rx_s2) armed <= 1'b1;
      if (state_q == IDLE || tick) cnt <= 12'd0;
      else cnt <= cnt + 12'd1;
      if (start_det) begin
        div_q     <= (baud_divisor < 12'd4) ? 12'd4 : baud_divisor;
        par_q     <= parity_sel;
        stop_q    <= stop_sel;
        idx       <= 3'd0;
        stop1_bad <= 1'b0;
      end
      if (state_q == DATA && tick) begin
        shreg <= {rx_s2, shreg[7:1]};
        idx   <= idx + 3'd1;
      end
      if (state_q == PARITY && tick) pbit_q <= rx_s2;
      if (state_q == STOP1 && tick) stop1_bad <= !rx_s2;
      if (done) begin
        data_out    <= shreg;
        valid_out   <= 1'b1;
        parity_err  <= perr_new;
        frame_err   <= ferr_new;
        overrun_err <= valid_out && !ready_in;
      end else if (consume) begin
        valid_out   <= 1'b0;
        parity_err  <= 1'b0;
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames with hand-computed bytes, flags, latencies.
module tb_uart_rx_frame;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        parity_sel = 1'b0;
  logic        stop_sel = 1'b0;
  logic [11:0] baud_divisor = 12'd16;
  logic        ready_in = 1'b0;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        parity_err;
  logic        frame_err;
  logic        overrun_err;
  logic        busy;

  int cyc = 0;
  int t0 = 0;
  int rise_edge = -1;
  int fall_edge = -1;
  int ready_edge = 0;
  bit pulse_done = 1'b0;
  bit pv = 1'b0;
  bit pb = 1'b0;
  int errs = 0;
  int nchk = 0;
  int bc;
  int vc;

  uart_rx_frame dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .parity_sel(parity_sel),
    .stop_sel(stop_sel),
    .baud_divisor(baud_divisor),
    .ready_in(ready_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overrun_err(overrun_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid_out && !pv) rise_edge = cyc;
    if (!busy && pb) fall_edge = cyc;
    pv = valid_out;
    pb = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ready_edge != 0) ready_in = (cyc + 1 == ready_edge);
  endtask

  task automatic send(input logic [7:0] b, input logic p,
                      input logic stop_lo, input int nstop, input int d);
    step();
    rx = 1'b0;
    t0 = cyc + 1;
    if (pulse_done) ready_edge = t0 + 2 + d / 2 + (nstop == 2 ? 11 : 10) * d;
    repeat (d) step();
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (d) step();
    end
    rx = p;
    repeat (d) step();
    for (int s = 0; s < nstop; s++) begin
      rx = !stop_lo;
      repeat (d) step();
    end
    ready_edge = 0;
    ready_in = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) step();
    chk("idle_bound", busy, 0);
  endtask

  task automatic consume();
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", valid_out, 0);
    chk("rst_flags", {parity_err, frame_err, overrun_err}, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (5) step();

    // 0xA5, even parity, 1 stop
    send(8'hA5, 1'b0, 1'b0, 1, 16);
    wait_idle();
    chk("a5_rise", rise_edge - t0, 170);
    chk("a5_fall", fall_edge - t0, 170);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_valid", valid_out, 1);
    chk("a5_flags", {parity_err, frame_err, overrun_err}, 0);
    consume();
    chk("a5_consumed", valid_out, 0);
    chk("a5_hold", data_out, 8'hA5);
    repeat (5) step();

    // 0x3C, odd parity with wrong parity bit, 2 stops
    parity_sel = 1'b1;
    stop_sel = 1'b1;
    send(8'h3C, 1'b0, 1'b0, 2, 16);
    wait_idle();
    chk("3c_rise", rise_edge - t0, 186);
    chk("3c_data", data_out, 8'h3C);
    chk("3c_perr", parity_err, 1);
    chk("3c_ferr", frame_err, 0);
    consume();
    chk("3c_consumed", {valid_out, parity_err}, 0);
    parity_sel = 1'b0;
    stop_sel = 1'b0;
    repeat (5) step();

    // low stop bit, then the line stays low
    send(8'h0F, 1'b0, 1'b1, 1, 16);
    chk("brk_data", data_out, 8'h0F);
    chk("brk_ferr", frame_err, 1);
    chk("brk_perr", parity_err, 0);
    bc = 0;
    for (int i = 0; i < 48; i++) begin
      if (busy) bc++;
      step();
    end
    chk("brk_no_retrig", bc, 0);
    consume();
    chk("brk_consumed", {valid_out, frame_err}, 0);
    rx = 1'b1;
    repeat (8) step();
    chk("brk_idle", busy, 0);

    // 3-cycle glitch
    step();
    rx = 1'b0;
    t0 = cyc + 1;
    repeat (3) step();
    rx = 1'b1;
    bc = 0;
    vc = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) bc++;
      if (valid_out) vc++;
      step();
    end
    chk("glitch_busy", bc, 8);
    chk("glitch_valid", vc, 0);
    chk("glitch_fall", fall_edge - t0, 10);

    // overrun: two frames, nobody consuming
    send(8'h11, 1'b0, 1'b0, 1, 16);
    repeat (5) step();
    send(8'h22, 1'b0, 1'b0, 1, 16);
    wait_idle();
    chk("ovr_data", data_out, 8'h22);
    chk("ovr_flag", overrun_err, 1);
    chk("ovr_valid", valid_out, 1);
    consume();
    chk("ovr_clear", {valid_out, parity_err, frame_err, overrun_err}, 0);
    repeat (5) step();

    // consume on the completion edge itself
    send(8'h11, 1'b0, 1'b0, 1, 16);
    repeat (5) step();
    pulse_done = 1'b1;
    send(8'h22, 1'b0, 1'b0, 1, 16);
    pulse_done = 1'b0;
    wait_idle();
    chk("same_fall", fall_edge - t0, 170);
    chk("same_data", data_out, 8'h22);
    chk("same_valid", valid_out, 1);
    chk("same_ovr", overrun_err, 0);

    // reset during data bit 4 with a byte still pending
    step();
    rx = 1'b0;
    repeat (16) step();
    for (int k = 0; k < 4; k++) begin
      rx = 1'b0;
      repeat (16) step();
    end
    repeat (8) step();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_out", {data_out, valid_out, parity_err,
                        frame_err, overrun_err, busy}, 0);
    rx = 1'b1;
    repeat (20) step();
    chk("mid_quiet", {valid_out, busy}, 0);
    send(8'h5A, 1'b0, 1'b0, 1, 16);
    wait_idle();
    chk("5a_fall", fall_edge - t0, 170);
    chk("5a_data", data_out, 8'h5A);
    chk("5a_valid", valid_out, 1);
    chk("5a_flags", {parity_err, frame_err, overrun_err}, 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
